id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV64 core; latches decoded fields plus bypassed operands from the ID forwarding unit.
//  Detects load-use hazards against the instruction it holds, inserts one bubble and stalls IF/ID; honours EX-redirect flush and memory stall.
//  Counts inserted load-use bubbles for performance monitoring.
// PARAMETERS
//  XLEN      64  datapath width (pc, imm, operands)
//  ALU_OP_W  4   ALU opcode width
//  CNT_W     32  bubble counter width
// PORTS
//  clk            in   1        core clock, all state updates on rising edge
//  rst            in   1        synchronous, active-high reset
//  id_valid       in   1        ID holds a live instruction
//  id_pc          in   XLEN     ID pc
//  id_inst        in   32       ID instruction word
//  id_rs1/id_rs2  in   5 each   source register indices
//  id_use_rs1/2   in   1 each   instruction actually reads rs1/rs2
//  id_rd          in   5        destination index
//  id_we          in   1        register write enable
//  id_mem_read    in   1        load
//  id_mem_write   in   1        store
//  id_alu_op      in   ALU_OP_W ALU opcode
//  id_imm         in   XLEN     immediate
//  id_rs1_data    in   XLEN     bypassed operand 1 (forwarding unit output)
//  id_rs2_data    in   XLEN     bypassed operand 2
//  flush_i        in   1        EX branch/jump redirect: kill ID instruction
//  mem_stall_i    in   1        downstream memory busy: freeze pipeline
//  ex_*           out  -        registered copy of every id_* field above (same widths), ex_valid incl.
//  stall_o        out  1        hold PC and IF/ID register this cycle (combinational)
//  bubble_cnt     out  CNT_W    number of load-use bubbles inserted
// BEHAVIOUR
//  Reset (rst=1 at edge): ex_valid/ex_we/ex_mem_read/ex_mem_write=0, ex_inst=32'h0000_0013 (NOP), all other ex_* = 0, bubble_cnt=0.
//  hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid &
//           ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  Per-edge update, priority order:
//   1 rst          -> reset values above.
//   2 mem_stall_i  -> all ex_* and bubble_cnt hold; flush_i ignored (issuer keeps flush_i high until stall clears).
//   3 flush_i      -> load bubble; bubble_cnt unchanged.
//   4 hazard       -> load bubble; bubble_cnt += 1, saturating at all-ones.
//   5 otherwise    -> ex_* <= id_* (ex_valid<=id_valid); invalid id captured as-is but ex_we/ex_mem_* forced 0 when id_valid=0.
//  Bubble = reset values of ex_* (valid/we/mem flags 0, inst NOP, data 0).
//  stall_o = mem_stall_i | (hazard & ~flush_i); no registered term, same-cycle.
//  Latency: 1 cycle ID->EX; load-use costs exactly 1 bubble (load then in MEM, forwarding supplies MEM data).
//  rd=x0 loads never cause a hazard; store data dependency on load (rs2) stalls like any use.
//  Back-to-back: after the bubble ex_valid=0, so hazard clears; stall_o never exceeds one cycle per load absent mem_stall_i.
//  rst mid-stall: all state cleared, stall_o depends only on inputs next cycle.
// STRUCTURE
//  pipe_pkg: NOP_INST constant, ALU op enum/width, id_ex_t struct bundling ex_* fields, XLEN default.
//  Sub-module load_use_detect (combinational): ex_valid/ex_mem_read/ex_rd vs id rs/use/valid -> hazard.
//  Top holds id_ex_t register, priority mux, saturating counter, stall_o logic.
// TESTING
//  T1 reset: rst=1 2 cycles with random id_* -> ex_valid=0, ex_inst=0x13, bubble_cnt=0, stall_o=0.
//  T2 load-use: ld x5 in EX, ID add x6,x5,x1 -> stall_o=1 one cycle, next ex_valid=0, then add enters EX, bubble_cnt=1.
//  T3 no false stall: ld x0 or id_use_rs2=0 with rs2=ex_rd, or ex non-load same rd -> stall_o=0, direct pass-through.
//  T4 flush vs hazard same cycle: hazard true, flush_i=1 -> stall_o=0, ex bubble, bubble_cnt unchanged.
//  T5 mem_stall_i 3 cycles during hazard and flush -> ex_* and bubble_cnt frozen, stall_o=1; on release flush acts.
//  T6 CNT_W=4, 20 load-use pairs -> bubble_cnt saturates at 4'hF, no wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline register of the RV64 core.
package pipe_pkg;

  localparam int XLEN     = 64;
  localparam int ALU_OP_W = 4;

  // addi x0, x0, 0 -- canonical RISC-V no-op placed in EX for every bubble
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Everything the EX stage needs about one instruction
  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [31:0]         inst;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic [4:0]          rd;
    logic                we;
    logic                mem_read;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
  } id_ex_t;

  // Bubble contents: nothing valid, no side effects, a NOP word for tracing
  function automatic id_ex_t bubble_entry();
    id_ex_t b;
    b      = '0;
    b.inst = NOP_INST;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the decode side (master) and the ID/EX register (slave).
interface id_ex_stage_if import pipe_pkg::*; #(
  parameter int CNT_W = 32
) ();

  logic                id_valid;
  logic [XLEN-1:0]     id_pc;
  logic [31:0]         id_inst;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [4:0]          id_rd;
  logic                id_we;
  logic                id_mem_read;
  logic                id_mem_write;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic [XLEN-1:0]     id_imm;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic                flush_i;
  logic                mem_stall_i;

  logic                ex_valid;
  logic [XLEN-1:0]     ex_pc;
  logic [31:0]         ex_inst;
  logic [4:0]          ex_rs1;
  logic [4:0]          ex_rs2;
  logic                ex_use_rs1;
  logic                ex_use_rs2;
  logic [4:0]          ex_rd;
  logic                ex_we;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [XLEN-1:0]     ex_imm;
  logic [XLEN-1:0]     ex_rs1_data;
  logic [XLEN-1:0]     ex_rs2_data;
  logic                stall_o;
  logic [CNT_W-1:0]    bubble_cnt;

  modport master (
    output id_valid, id_pc, id_inst, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_mem_read, id_mem_write, id_alu_op, id_imm,
           id_rs1_data, id_rs2_data, flush_i, mem_stall_i,
    input  ex_valid, ex_pc, ex_inst, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
           ex_rd, ex_we, ex_mem_read, ex_mem_write, ex_alu_op, ex_imm,
           ex_rs1_data, ex_rs2_data, stall_o, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_inst, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_we, id_mem_read, id_mem_write, id_alu_op, id_imm,
           id_rs1_data, id_rs2_data, flush_i, mem_stall_i,
    output ex_valid, ex_pc, ex_inst, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
           ex_rd, ex_we, ex_mem_read, ex_mem_write, ex_alu_op, ex_imm,
           ex_rs1_data, ex_rs2_data, stall_o, bubble_cnt
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load sitting in EX whose result the ID
// instruction needs cannot be forwarded in time, so one bubble is required.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hazard
);

  logic rs1_dep;
  logic rs2_dep;

  // x0 loads are excluded: their result is discarded so nothing waits on it
  always_comb begin
    rs1_dep = id_use_rs1 & (id_rs1 == ex_rd);
    rs2_dep = id_use_rs2 & (id_rs2 == ex_rd);
    hazard  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & (rs1_dep | rs2_dep);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-redirect flush,
// memory-stall freeze and a saturating count of inserted load-use bubbles.
module id_ex_stage import pipe_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  logic             hazard;
  id_ex_t           id_entry;
  id_ex_t           ex_d;
  id_ex_t           ex_q;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_rd       (ex_q.rd),
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .hazard      (hazard)
  );

  // Gather ID fields; side-effect flags are masked so a dead slot cannot write
  always_comb begin
    id_entry           = '0;
    id_entry.valid     = bus.id_valid;
    id_entry.pc        = bus.id_pc;
    id_entry.inst      = bus.id_inst;
    id_entry.rs1       = bus.id_rs1;
    id_entry.rs2       = bus.id_rs2;
    id_entry.use_rs1   = bus.id_use_rs1;
    id_entry.use_rs2   = bus.id_use_rs2;
    id_entry.rd        = bus.id_rd;
    id_entry.we        = bus.id_we & bus.id_valid;
    id_entry.mem_read  = bus.id_mem_read & bus.id_valid;
    id_entry.mem_write = bus.id_mem_write & bus.id_valid;
    id_entry.alu_op    = bus.id_alu_op;
    id_entry.imm       = bus.id_imm;
    id_entry.rs1_data  = bus.id_rs1_data;
    id_entry.rs2_data  = bus.id_rs2_data;
  end

  // Next EX contents: freeze beats flush beats load-use bubble beats advance
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.mem_stall_i) begin
      ex_d         = ex_q;
    end else if (bus.flush_i) begin
      ex_d         = bubble_entry();
    end else if (hazard) begin
      ex_d         = bubble_entry();
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d         = id_entry;
    end
  end

  // Pipeline register and bubble counter, cleared synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= bubble_entry();
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // A flushed instruction never needs its operand, so it must not stall fetch
  assign bus.stall_o = bus.mem_stall_i | (hazard & ~bus.flush_i);

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_inst      = ex_q.inst;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_use_rs1   = ex_q.use_rs1;
  assign bus.ex_use_rs2   = ex_q.use_rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_we        = ex_q.we;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_alu_op    = ex_q.alu_op;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs1_data  = ex_q.rs1_data;
  assign bus.ex_rs2_data  = ex_q.rs2_data;
  assign bus.bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model pushes the expected
// EX contents when stimulus is applied, popped and compared after the edge.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_ex_stage_if #(.CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  id_ex_t           mdl_ex;
  logic [CNT_W-1:0] mdl_cnt;
  bit               mdl_known = 1'b0;
  logic             last_stall;

  id_ex_t           exp_ex_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];

  // Reset / bubble contents of the EX register
  function automatic id_ex_t bench_bubble();
    id_ex_t b;
    b      = '0;
    b.inst = 32'h0000_0013;
    return b;
  endfunction

  // What the EX register should hold when ID advances
  function automatic id_ex_t id_fields();
    id_ex_t e;
    e.valid     = bus.id_valid;
    e.pc        = bus.id_pc;
    e.inst      = bus.id_inst;
    e.rs1       = bus.id_rs1;
    e.rs2       = bus.id_rs2;
    e.use_rs1   = bus.id_use_rs1;
    e.use_rs2   = bus.id_use_rs2;
    e.rd        = bus.id_rd;
    e.we        = bus.id_valid ? bus.id_we : 1'b0;
    e.mem_read  = bus.id_valid ? bus.id_mem_read : 1'b0;
    e.mem_write = bus.id_valid ? bus.id_mem_write : 1'b0;
    e.alu_op    = bus.id_alu_op;
    e.imm       = bus.id_imm;
    e.rs1_data  = bus.id_rs1_data;
    e.rs2_data  = bus.id_rs2_data;
    return e;
  endfunction

  // Collect the DUT's EX outputs into one comparable word
  function automatic id_ex_t observed_ex();
    id_ex_t o;
    o.valid     = bus.ex_valid;
    o.pc        = bus.ex_pc;
    o.inst      = bus.ex_inst;
    o.rs1       = bus.ex_rs1;
    o.rs2       = bus.ex_rs2;
    o.use_rs1   = bus.ex_use_rs1;
    o.use_rs2   = bus.ex_use_rs2;
    o.rd        = bus.ex_rd;
    o.we        = bus.ex_we;
    o.mem_read  = bus.ex_mem_read;
    o.mem_write = bus.ex_mem_write;
    o.alu_op    = bus.ex_alu_op;
    o.imm       = bus.ex_imm;
    o.rs1_data  = bus.ex_rs1_data;
    o.rs2_data  = bus.ex_rs2_data;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setInst(input bit valid, input logic [4:0] rs1, input bit use1,
                         input logic [4:0] rs2, input bit use2, input logic [4:0] rd,
                         input bit we, input bit mr, input bit mw);
    bus.id_valid     = valid;
    bus.id_pc        = {$urandom, $urandom};
    bus.id_inst      = $urandom;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = use1;
    bus.id_use_rs2   = use2;
    bus.id_rd        = rd;
    bus.id_we        = we;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_alu_op    = 4'($urandom_range(0, 15));
    bus.id_imm       = {$urandom, $urandom};
    bus.id_rs1_data  = {$urandom, $urandom};
    bus.id_rs2_data  = {$urandom, $urandom};
  endtask

  // One clock of stimulus: check stall_o, queue the expectation, clock, compare
  task automatic applyStimulus();
    logic             hz;
    logic             exp_stall;
    id_ex_t           nxt;
    logic [CNT_W-1:0] ncnt;
    id_ex_t           exp_ex;
    logic [CNT_W-1:0] exp_cnt;
    #1;
    hz = mdl_ex.valid & mdl_ex.mem_read & (mdl_ex.rd != 5'd0) & bus.id_valid &
         ((bus.id_use_rs1 & (bus.id_rs1 == mdl_ex.rd)) |
          (bus.id_use_rs2 & (bus.id_rs2 == mdl_ex.rd)));
    exp_stall  = bus.mem_stall_i | (hz & ~bus.flush_i);
    last_stall = bus.stall_o;
    if (mdl_known) checkOutput("stall_o", 320'(bus.stall_o), 320'(exp_stall));
    nxt  = mdl_ex;
    ncnt = mdl_cnt;
    if (rst) begin
      nxt  = bench_bubble();
      ncnt = '0;
    end else if (bus.mem_stall_i) begin
      nxt  = mdl_ex;
    end else if (bus.flush_i) begin
      nxt  = bench_bubble();
    end else if (hz) begin
      nxt  = bench_bubble();
      ncnt = (mdl_cnt == 4'hF) ? mdl_cnt : mdl_cnt + 4'd1;
    end else begin
      nxt  = id_fields();
    end
    exp_ex_q.push_back(nxt);
    exp_cnt_q.push_back(ncnt);
    @(posedge clk);
    #1;
    mdl_ex    = nxt;
    mdl_cnt   = ncnt;
    mdl_known = 1'b1;
    exp_ex    = exp_ex_q.pop_front();
    exp_cnt   = exp_cnt_q.pop_front();
    checkOutput("ex_regs", 320'(observed_ex()), 320'(exp_ex));
    checkOutput("bubble_cnt", 320'(bus.bubble_cnt), 320'(exp_cnt));
  endtask

  // Directed sequence: reset, load-use, false-stall cases, flush, freeze, saturation
  initial begin
    mdl_ex          = bench_bubble();
    mdl_cnt         = '0;
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.mem_stall_i = 1'b0;

    setInst(1, 5'd3, 1, 5'd4, 1, 5'd7, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd7, 1, 5'd7, 1, 5'd9, 1, 1, 0);
    applyStimulus();
    checkOutput("t1_ex_valid", 320'(bus.ex_valid), 320'(1'b0));
    checkOutput("t1_ex_inst", 320'(bus.ex_inst), 320'(32'h13));
    checkOutput("t1_cnt", 320'(bus.bubble_cnt), 320'(4'd0));
    checkOutput("t1_stall", 320'(last_stall), 320'(1'b0));
    rst = 1'b0;

    setInst(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    applyStimulus();
    checkOutput("t2_stall_hi", 320'(last_stall), 320'(1'b1));
    checkOutput("t2_bubble", 320'(bus.ex_valid), 320'(1'b0));
    applyStimulus();
    checkOutput("t2_stall_lo", 320'(last_stall), 320'(1'b0));
    checkOutput("t2_add_rd", 320'(bus.ex_rd), 320'(5'd6));
    checkOutput("t2_cnt", 320'(bus.bubble_cnt), 320'(4'd1));

    setInst(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0);
    applyStimulus();
    checkOutput("t3_x0_stall", 320'(last_stall), 320'(1'b0));
    setInst(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd3, 1, 5'd7, 0, 5'd10, 1, 0, 0);
    applyStimulus();
    checkOutput("t3_unused_rs2", 320'(last_stall), 320'(1'b0));
    setInst(1, 5'd4, 1, 5'd4, 1, 5'd9, 1, 0, 0);
    applyStimulus();
    setInst(1, 5'd9, 1, 5'd9, 1, 5'd11, 1, 0, 0);
    applyStimulus();
    checkOutput("t3_nonload", 320'(last_stall), 320'(1'b0));
    setInst(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd2, 1, 5'd8, 1, 5'd0, 0, 0, 1);
    applyStimulus();
    checkOutput("t3_store_stall", 320'(last_stall), 320'(1'b1));
    applyStimulus();
    checkOutput("t3_store_in_ex", 320'(bus.ex_mem_write), 320'(1'b1));
    checkOutput("t3_cnt", 320'(bus.bubble_cnt), 320'(4'd2));

    setInst(1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd10, 1, 5'd0, 0, 5'd12, 1, 0, 0);
    bus.flush_i = 1'b1;
    applyStimulus();
    checkOutput("t4_stall", 320'(last_stall), 320'(1'b0));
    checkOutput("t4_bubble", 320'(bus.ex_valid), 320'(1'b0));
    checkOutput("t4_cnt", 320'(bus.bubble_cnt), 320'(4'd2));
    bus.flush_i = 1'b0;

    setInst(1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd11, 1, 5'd0, 0, 5'd13, 1, 0, 0);
    bus.mem_stall_i = 1'b1;
    bus.flush_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t5_stall", 320'(last_stall), 320'(1'b1));
    end
    checkOutput("t5_frozen_rd", 320'(bus.ex_rd), 320'(5'd11));
    checkOutput("t5_frozen_ld", 320'(bus.ex_mem_read), 320'(1'b1));
    bus.mem_stall_i = 1'b0;
    applyStimulus();
    checkOutput("t5_release_stall", 320'(last_stall), 320'(1'b0));
    checkOutput("t5_flushed", 320'(bus.ex_valid), 320'(1'b0));
    checkOutput("t5_cnt", 320'(bus.bubble_cnt), 320'(4'd2));
    bus.flush_i = 1'b0;

    setInst(0, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1);
    applyStimulus();
    checkOutput("invalid_we", 320'(bus.ex_we), 320'(1'b0));

    for (int i = 0; i < 20; i++) begin
      setInst(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 0);
      applyStimulus();
      setInst(1, 5'd3, 1, 5'd12, 1, 5'd14, 1, 0, 0);
      applyStimulus();
      applyStimulus();
    end
    checkOutput("t6_saturate", 320'(bus.bubble_cnt), 320'(4'hF));

    setInst(1, 5'd1, 1, 5'd0, 0, 5'd13, 1, 1, 0);
    applyStimulus();
    setInst(1, 5'd13, 1, 5'd0, 0, 5'd15, 1, 0, 0);
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst_mid_cnt", 320'(bus.bubble_cnt), 320'(4'd0));
    checkOutput("rst_mid_valid", 320'(bus.ex_valid), 320'(1'b0));
    rst = 1'b0;
    applyStimulus();
    checkOutput("rst_mid_stall", 320'(last_stall), 320'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
